// File: rtl/pc_pkg.sv
// Shared definitions for the per-core program counter: op encoding and reset vector.
package pc_pkg;

  localparam int PC_W_DEF   = 16;
  localparam int PC_RST_VAL = 0;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_STALL,
    OP_WRITE,
    OP_CALL,
    OP_RET,
    OP_BR,
    OP_INC
  } op_e;

  // One op per cycle; earlier tests win, later requests are dropped.
  function automatic op_e decode_op(input logic stall, input logic write,
                                    input logic call, input logic ret,
                                    input logic br, input logic inc);
    if (stall)      return OP_STALL;
    else if (write) return OP_WRITE;
    else if (call)  return OP_CALL;
    else if (ret)   return OP_RET;
    else if (br)    return OP_BR;
    else if (inc)   return OP_INC;
    else            return OP_NONE;
  endfunction

endpackage

// File: rtl/pc_stack_unit_if.sv
// Request/status bundle between fetch/control and the program counter unit.
// Requests are level signals sampled on every rising clk edge; there is no handshake.
interface pc_stack_unit_if
  import pc_pkg::*;
#(
   parameter int PC_W        = PC_W_DEF,
   parameter int STACK_DEPTH = 4
);
   localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

   logic               stall;
   logic               write;
   logic               inc;
   logic               br;
   logic               call;
   logic               ret;
   logic               clr_err;
   logic [PC_W-1:0]    offset;
   logic [PC_W-1:0]    data_in;
   logic [PC_W-1:0]    data_out;
   logic [DEPTH_W-1:0] depth;
   logic               ovf;
   logic               unf;
   logic               halted;

   modport master (
      output stall, write, inc, br, call, ret, clr_err, offset, data_in,
      input  data_out, depth, ovf, unf, halted
   );

   modport slave (
      input  stall, write, inc, br, call, ret, clr_err, offset, data_in,
      output data_out, depth, ovf, unf, halted
   );
endinterface

// File: rtl/pc_stack_unit_ras_lifo.sv
// Return-address LIFO: count is reset, entry storage is not.
module ras_lifo
  import pc_pkg::*;
#(
   parameter int W     = PC_W_DEF,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [W-1:0]  i_din,
   output logic [W-1:0]  o_top,
   output logic          o_full,
   output logic          o_empty,
   output logic [CW-1:0] o_count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_m1;

   assign w_count_m1 = r_count - CW'(1);
   assign o_full     = (r_count == CW'(DEPTH));
   assign o_empty    = (r_count == '0);
   assign o_count    = r_count;
   assign o_top      = r_mem[w_count_m1[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_push && !o_full) begin
         r_count <= r_count + CW'(1);
      end else if (i_pop && !o_empty) begin
         r_count <= w_count_m1;
      end
   end

   always_ff @(posedge clk) begin
      if (i_push && !o_full) r_mem[r_count[AW-1:0]] <= i_din;
   end
endmodule

// File: rtl/pc_stack_unit.sv
// Per-core PC with stall, relative branch, call/return stack and sticky stack errors.
// Define PC_HALT_EN to freeze the PC once it reaches HALT_ADDR.
module pc_stack_unit
  import pc_pkg::*;
#(
   parameter int              PC_W        = PC_W_DEF,
   parameter int              STACK_DEPTH = 4,
   parameter logic [PC_W-1:0] HALT_ADDR   = {PC_W{1'b1}}
) (
   input logic              clk,
   input logic              rst,
   pc_stack_unit_if.slave   bus
);
   localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

   op_e                w_op;
   logic [PC_W-1:0]    r_pc;
   logic [PC_W-1:0]    w_pc_nxt;
   logic [PC_W-1:0]    w_top;
   logic [PC_W-1:0]    w_ret_addr;
   logic               w_push;
   logic               w_pop;
   logic               w_full;
   logic               w_empty;
   logic               w_frozen;
   logic [DEPTH_W-1:0] w_count;
   logic               r_ovf;
   logic               r_unf;

`ifdef PC_HALT_EN
   logic r_halted;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_halted <= 1'b0;
      else if (w_op != OP_STALL && w_pc_nxt == HALT_ADDR)
         r_halted <= 1'b1;
   end

   assign w_frozen   = r_halted;
   assign bus.halted = r_halted;
`else
   logic w_unused_halt;
   assign w_unused_halt = ^HALT_ADDR;
   assign w_frozen      = 1'b0;
   assign bus.halted    = 1'b0;
`endif

   // A halted core still honours stall, but every other request is dropped.
   always_comb begin
      w_op = decode_op(bus.stall, bus.write, bus.call, bus.ret, bus.br, bus.inc);
      if (w_frozen && w_op != OP_STALL) w_op = OP_NONE;
   end

   assign w_ret_addr = r_pc + PC_W'(1);

   always_comb begin
      w_pc_nxt = r_pc;
      w_push   = 1'b0;
      w_pop    = 1'b0;
      case (w_op)
         OP_WRITE: w_pc_nxt = bus.data_in;
         OP_CALL: begin
            w_pc_nxt = bus.data_in;
            w_push   = !w_full;
         end
         OP_RET: begin
            if (!w_empty) begin
               w_pc_nxt = w_top;
               w_pop    = 1'b1;
            end
         end
         OP_BR:   w_pc_nxt = r_pc + bus.offset;
         OP_INC:  w_pc_nxt = w_ret_addr;
         default: w_pc_nxt = r_pc;
      endcase
   end

   // Error set takes precedence over clr_err in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc  <= PC_W'(PC_RST_VAL);
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else if (w_op != OP_STALL) begin
         r_pc <= w_pc_nxt;
         if (w_op == OP_CALL && w_full) r_ovf <= 1'b1;
         else if (bus.clr_err)          r_ovf <= 1'b0;
         if (w_op == OP_RET && w_empty) r_unf <= 1'b1;
         else if (bus.clr_err)          r_unf <= 1'b0;
      end
   end

   ras_lifo #(
      .W     (PC_W),
      .DEPTH (STACK_DEPTH),
      .CW    (DEPTH_W)
   ) u_ras (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_din   (w_ret_addr),
      .o_top   (w_top),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign bus.data_out = r_pc;
   assign bus.depth    = w_count;
   assign bus.ovf      = r_ovf;
   assign bus.unf      = r_unf;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Table-driven bench for pc_stack_unit with an expected-value queue.
module tb_pc_stack_unit;
  localparam int PC_W = 16;
  localparam int SD   = 4;
  localparam int EW   = PC_W + 3 + 3;

`ifdef PC_HALT_EN
  localparam bit HALT_ON = 1'b1;
`else
  localparam bit HALT_ON = 1'b0;
`endif

  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_STALL = 7'b1000000;
  localparam logic [6:0] C_WRITE = 7'b0100000;
  localparam logic [6:0] C_CALL  = 7'b0010000;
  localparam logic [6:0] C_RET   = 7'b0001000;
  localparam logic [6:0] C_BR    = 7'b0000100;
  localparam logic [6:0] C_INC   = 7'b0000010;
  localparam logic [6:0] C_CLR   = 7'b0000001;

  typedef struct packed {
    logic [6:0]      ctrl;
    logic [PC_W-1:0] offset;
    logic [PC_W-1:0] data;
    logic [PC_W-1:0] e_pc;
    logic [2:0]      e_depth;
    logic            e_ovf;
    logic            e_unf;
    logic            e_halt;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  logic [EW-1:0] exp_q[$];
  vec_t          tbl[$];

  pc_stack_unit_if #(.PC_W(PC_W), .STACK_DEPTH(SD)) bus ();

  pc_stack_unit #(
    .PC_W        (PC_W),
    .STACK_DEPTH (SD),
    .HALT_ADDR   (16'h0008)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [6:0] ctrl, input logic [15:0] offset,
                              input logic [15:0] data, input logic [15:0] e_pc,
                              input logic [2:0] e_depth, input logic e_ovf,
                              input logic e_unf, input logic e_halt);
    vec_t v;
    v.ctrl    = ctrl;
    v.offset  = offset;
    v.data    = data;
    v.e_pc    = e_pc;
    v.e_depth = e_depth;
    v.e_ovf   = e_ovf;
    v.e_unf   = e_unf;
    v.e_halt  = e_halt;
    return v;
  endfunction

  // scoreboard
  task automatic check(input string name);
    logic [EW-1:0] act;
    logic [EW-1:0] exp;
    act = {bus.data_out, bus.depth, bus.ovf, bus.unf, bus.halted};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: no expected entry queued, got pc=%h depth=%0d ovf=%b unf=%b halted=%b",
               name, act[EW-1:6], act[5:3], act[2], act[1], act[0]);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_err++;
        $display("FAIL %s: got pc=%h depth=%0d ovf=%b unf=%b halted=%b, expected pc=%h depth=%0d ovf=%b unf=%b halted=%b",
                 name, act[EW-1:6], act[5:3], act[2], act[1], act[0],
                 exp[EW-1:6], exp[5:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  // driver
  task automatic drive_idle();
    {bus.stall, bus.write, bus.call, bus.ret, bus.br, bus.inc, bus.clr_err} = C_NONE;
    bus.offset  = '0;
    bus.data_in = '0;
  endtask

  task automatic step(input vec_t v, input string name);
    {bus.stall, bus.write, bus.call, bus.ret, bus.br, bus.inc, bus.clr_err} = v.ctrl;
    bus.offset  = v.offset;
    bus.data_in = v.data;
    exp_q.push_back({v.e_pc, v.e_depth, v.e_ovf, v.e_unf, v.e_halt});
    @(posedge clk);
    #1;
    check(name);
  endtask

  task automatic expect_now(input logic [15:0] pc, input logic [2:0] d,
                            input logic o, input logic u, input logic h,
                            input string name);
    exp_q.push_back({pc, d, o, u, h});
    check(name);
  endtask

  initial begin
    logic [15:0] e_pc;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    expect_now(16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, "reset");
    rst = 1'b0;

    // inc from reset, then async reset mid-count
    for (int i = 1; i <= 5; i++)
      step(mk(C_INC, 16'h0, 16'h0, 16'(i), 3'd0, 1'b0, 1'b0, 1'b0), $sformatf("inc%0d", i));
    bus.inc = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    expect_now(16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, "rst_async");
    bus.inc = 1'b0;
    #2;
    rst = 1'b0;

    // call/return, stack overflow/underflow, clr_err, branch wrap, priority
    tbl.push_back(mk(C_WRITE,                16'h0,    16'h0024, 16'h0024, 3'd0, 0, 0, 0));
    tbl.push_back(mk(C_CALL,                 16'h0,    16'h0100, 16'h0100, 3'd1, 0, 0, 0));
    tbl.push_back(mk(C_RET,                  16'h0,    16'h0,    16'h0025, 3'd0, 0, 0, 0));
    tbl.push_back(mk(C_CALL,                 16'h0,    16'h0010, 16'h0010, 3'd1, 0, 0, 0));
    tbl.push_back(mk(C_CALL,                 16'h0,    16'h0011, 16'h0011, 3'd2, 0, 0, 0));
    tbl.push_back(mk(C_CALL,                 16'h0,    16'h0012, 16'h0012, 3'd3, 0, 0, 0));
    tbl.push_back(mk(C_CALL,                 16'h0,    16'h0013, 16'h0013, 3'd4, 0, 0, 0));
    tbl.push_back(mk(C_CALL,                 16'h0,    16'h0014, 16'h0014, 3'd4, 1, 0, 0));
    tbl.push_back(mk(C_STALL|C_RET|C_CLR,    16'h0,    16'h0,    16'h0014, 3'd4, 1, 0, 0));
    tbl.push_back(mk(C_RET,                  16'h0,    16'h0,    16'h0013, 3'd3, 1, 0, 0));
    tbl.push_back(mk(C_RET,                  16'h0,    16'h0,    16'h0012, 3'd2, 1, 0, 0));
    tbl.push_back(mk(C_RET,                  16'h0,    16'h0,    16'h0011, 3'd1, 1, 0, 0));
    tbl.push_back(mk(C_RET,                  16'h0,    16'h0,    16'h0026, 3'd0, 1, 0, 0));
    tbl.push_back(mk(C_RET,                  16'h0,    16'h0,    16'h0026, 3'd0, 1, 1, 0));
    tbl.push_back(mk(C_STALL|C_CLR,          16'h0,    16'h0,    16'h0026, 3'd0, 1, 1, 0));
    tbl.push_back(mk(C_CLR,                  16'h0,    16'h0,    16'h0026, 3'd0, 0, 0, 0));
    tbl.push_back(mk(C_RET|C_CLR,            16'h0,    16'h0,    16'h0026, 3'd0, 0, 1, 0));
    tbl.push_back(mk(C_CLR,                  16'h0,    16'h0,    16'h0026, 3'd0, 0, 0, 0));
    tbl.push_back(mk(C_WRITE,                16'h0,    16'h0002, 16'h0002, 3'd0, 0, 0, 0));
    tbl.push_back(mk(C_BR,                   16'hFFFC, 16'h0,    16'hFFFE, 3'd0, 0, 0, 0));
    tbl.push_back(mk(C_INC,                  16'h0,    16'h0,    16'hFFFF, 3'd0, 0, 0, 0));
    tbl.push_back(mk(C_INC,                  16'h0,    16'h0,    16'h0000, 3'd0, 0, 0, 0));
    tbl.push_back(mk(C_BR,                   16'h0010, 16'h0,    16'h0010, 3'd0, 0, 0, 0));
    tbl.push_back(mk(C_WRITE,                16'h0,    16'hFFF0, 16'hFFF0, 3'd0, 0, 0, 0));
    tbl.push_back(mk(C_BR,                   16'h0020, 16'h0,    16'h0010, 3'd0, 0, 0, 0));
    tbl.push_back(mk(C_WRITE|C_CALL|C_INC,   16'h0,    16'h00E5, 16'h00E5, 3'd0, 0, 0, 0));
    tbl.push_back(mk(C_CALL,                 16'h0,    16'h0200, 16'h0200, 3'd1, 0, 0, 0));
    tbl.push_back(mk(C_WRITE|C_CALL|C_INC,   16'h0,    16'h00E5, 16'h00E5, 3'd1, 0, 0, 0));
    tbl.push_back(mk(C_STALL|C_WRITE|C_CALL|C_INC, 16'h0, 16'h0777, 16'h00E5, 3'd1, 0, 0, 0));
    tbl.push_back(mk(C_CALL|C_RET|C_BR|C_INC, 16'h0005, 16'h0300, 16'h0300, 3'd2, 0, 0, 0));
    tbl.push_back(mk(C_RET|C_BR|C_INC,       16'h0005, 16'h0,    16'h00E6, 3'd1, 0, 0, 0));
    tbl.push_back(mk(C_BR|C_INC,             16'h0005, 16'h0,    16'h00EB, 3'd1, 0, 0, 0));
    tbl.push_back(mk(C_NONE,                 16'h0,    16'h0,    16'h00EB, 3'd1, 0, 0, 0));
    tbl.push_back(mk(C_RET,                  16'h0,    16'h0,    16'h00E6, 3'd0, 0, 0, 0));

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // halt region: count through 8 from a fresh reset
    drive_idle();
    rst = 1'b1;
    #1;
    expect_now(16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, "rst_pre_halt");
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 10; i++) begin
      e_pc = (HALT_ON && i > 8) ? 16'h0008 : 16'(i);
      step(mk(C_INC, 16'h0, 16'h0, e_pc, 3'd0, 1'b0, 1'b0, HALT_ON && i >= 8),
           $sformatf("halt_inc%0d", i));
    end
    step(mk(C_WRITE, 16'h0, 16'h0050, HALT_ON ? 16'h0008 : 16'h0050, 3'd0, 1'b0, 1'b0, HALT_ON),
         "halt_write");
    drive_idle();
    rst = 1'b1;
    #1;
    expect_now(16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, "rst_clears_halt");
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover: %0d expected entries never compared, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // hard stop so a stuck run still reports
  initial begin
    #200000;
    n_err++;
    $display("FAIL timeout: simulation exceeded time limit, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
